seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGITS, default 6, number of multiplexed digits (2..8).
REQ-002 Parameter SCAN_DIV, default 100000, clock cycles each digit is driven (1 ms at 100 MHz), minimum 2.
REQ-003 Parameter BLANK_CYC, default 1000, anti-ghost blanking cycles between digits, minimum 1.
REQ-004 Parameter SEG_ACT_LOW, default 0; 1 inverts all seg and digit output bits.
REQ-005 clk  input  1  system clock, 100 MHz nominal.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 wr_en  input  1  digit-register write strobe, one cycle per write.
REQ-008 wr_addr  input  3  target digit index, 0 = rightmost.
REQ-009 wr_data  input  4  hex nibble for the target digit.
REQ-010 wr_dp  input  1  decimal-point bit for the target digit.
REQ-011 wr_blank  input  1  1 = suppress the target digit.
REQ-012 digit  output  DIGITS  one-hot digit select, registered.
REQ-013 seg  output  8  segments {dp,g,f,e,d,c,b,a}, registered.
REQ-014 scan_idx  output  3  index of the digit slot currently in progress.

Function
REQ-015 The block SHALL hold per digit a 4-bit value, a dp bit and a blank bit in registers.
REQ-016 On wr_en with wr_addr < DIGITS, the block SHALL write {wr_data, wr_dp, wr_blank} into that digit's registers on the same clock edge.
REQ-017 On wr_en with wr_addr >= DIGITS, the block SHALL ignore the write and change no state.
REQ-018 The scan FSM SHALL have exactly two states, BLANK and DRIVE, plus one cycle counter.
REQ-019 BLANK SHALL last BLANK_CYC cycles, with digit all-inactive and seg all-inactive.
REQ-020 DRIVE SHALL last SCAN_DIV cycles.
REQ-021 During DRIVE, digit SHALL be one-hot at bit scan_idx, unless that digit's blank bit is set, in which case digit stays all-inactive.
REQ-022 During DRIVE, seg SHALL be {dp, decode(value)} for digit scan_idx.
REQ-023 Decode SHALL use the standard hex glyphs 0-9, A, b, C, d, E, F.
REQ-024 On the DRIVE-to-BLANK transition, scan_idx SHALL increment; at DIGITS-1 it SHALL wrap to 0.
REQ-025 The full refresh period SHALL be DIGITS*(SCAN_DIV+BLANK_CYC) cycles exactly.
REQ-026 Outputs SHALL be registered: digit and seg reflect FSM state and register contents one cycle after the edge that produced them.
REQ-027 A write to the digit currently in DRIVE SHALL appear on seg/digit on the second edge after wr_en is sampled, without disturbing scan timing.
REQ-028 A write coinciding with a state transition SHALL take effect, and the new slot SHALL display the written value.
REQ-029 With SEG_ACT_LOW=1, every "inactive" level above SHALL be logic 1.
REQ-030 A digit SHALL never be active in the same cycle as segment data belonging to another digit.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in BLANK, the counter at 0, and scan_idx at 0.
REQ-032 While rst_n=0, all value, dp and blank registers SHALL be 0, and digit and seg SHALL be all-inactive.
REQ-033 Reset asserted mid-DRIVE SHALL deactivate digit immediately (asynchronously).
REQ-034 After rst_n deasserts, the first DRIVE SHALL start on digit 0 after BLANK_CYC cycles.

Structure
REQ-035 A shared package seg_pkg SHALL hold the 16-entry glyph constants, the segment bit-position constants and the FSM state encoding.
REQ-036 Hex-to-segment decode SHALL be a combinational sub-module named seg_dec (4-bit in, 7-bit out).
REQ-037 seg_scan SHALL instantiate exactly one seg_dec, shared across digits via scan_idx.

Verification
Bench parameters for all scenarios: DIGITS=6, SCAN_DIV=4, BLANK_CYC=1, SEG_ACT_LOW=0.
REQ-038 Reset release, no writes -> seg=8'h3F ("0") on each slot; digit sequence 000001, 000010 ... 100000 repeating; each slot 4 cycles followed by 1 cycle of zeros; period 30 cycles.
REQ-039 Write addr=2, data=4'hA, dp=1 -> during slot 2, digit=6'b000100 and seg=8'hF7.
REQ-040 Write addr=3 with blank=1 -> digit=0 for all of slot 3; the other slots are unchanged.
REQ-041 Write addr=6 and addr=7 -> no register changes; display identical to the reset state.
REQ-042 Write addr=1, data=4'h5 in the 2nd cycle of slot 1 -> seg changes from 8'h3F to 8'h6D two edges later; slot length is still 4 cycles.
REQ-043 rst_n pulsed low in the middle of slot 4 -> digit=0 and seg=0 immediately; scan restarts at digit 0 after 1 blank cycle; all registers cleared.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// glyph table, segment bit positions and scan FSM state encoding.
package seg_pkg;

  // Segment bit positions inside the 8-bit seg bus {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex glyphs as {g,f,e,d,c,b,a}, active-high; leftmost entry is index 15 (F)
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Scan FSM: a blanking gap followed by the drive window of the same slot
  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_dec.sv
// Combinational hex nibble to seven-segment decoder (active-high a..g).
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  logic [6:0] w_glyph;

  assign w_glyph = GLYPH_TABLE[i_hex];

  // Route each glyph column to its named segment position
  assign o_seg[SEG_A] = w_glyph[SEG_A];
  assign o_seg[SEG_B] = w_glyph[SEG_B];
  assign o_seg[SEG_C] = w_glyph[SEG_C];
  assign o_seg[SEG_D] = w_glyph[SEG_D];
  assign o_seg[SEG_E] = w_glyph[SEG_E];
  assign o_seg[SEG_F] = w_glyph[SEG_F];
  assign o_seg[SEG_G] = w_glyph[SEG_G];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed seven-segment display scanner. Each digit slot is a short
// all-off blanking gap (anti-ghosting) followed by a drive window. Digit and
// segment outputs are registered together from the same slot index, so a
// digit is never lit with another digit's segment pattern.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int SCAN_DIV    = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              wr_dp,
  input  logic              wr_blank,
  output logic [DIGITS-1:0] digit,
  output logic [7:0]        seg,
  output logic [2:0]        scan_idx
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0]  DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]        IDX_LAST   = 3'(DIGITS - 1);
  localparam logic              ACT_LOW    = (SEG_ACT_LOW != 0);
  localparam logic [DIGITS-1:0] DIG_OFF    = {DIGITS{ACT_LOW}};
  localparam logic [7:0]        SEG_OFF    = {8{ACT_LOW}};

  // Per-digit display contents
  logic [DIGITS-1:0][3:0] r_val;
  logic [DIGITS-1:0]      r_dp;
  logic [DIGITS-1:0]      r_blank;

  // Scan FSM state
  scan_state_t r_state;
  scan_state_t w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0] r_scan_idx;
  logic [2:0] w_idx_next;

  // Output registers and their next values
  logic [DIGITS-1:0] r_digit;
  logic [DIGITS-1:0] w_digit_next;
  logic [7:0]        r_seg;
  logic [7:0]        w_seg_next;

  // Contents of the slot being scanned
  logic [3:0]        w_cur_val;
  logic              w_cur_dp;
  logic              w_cur_blank;
  logic [6:0]        w_dec;
  logic [DIGITS-1:0] w_onehot;

  // Digit register write port; addresses beyond DIGITS-1 match no slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= '0;
      r_dp    <= '0;
      r_blank <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en && (wr_addr == 3'(i))) begin
          r_val[i]   <= wr_data;
          r_dp[i]    <= wr_dp;
          r_blank[i] <= wr_blank;
        end
      end
    end
  end

  // Select the contents of the slot currently being scanned
  always_comb begin
    w_cur_val   = '0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scan_idx == 3'(i)) begin
        w_cur_val   = r_val[i];
        w_cur_dp    = r_dp[i];
        w_cur_blank = r_blank[i];
      end
    end
  end

  // Single decoder shared by all digits through the scan index
  seg_dec u_seg_dec (
    .i_hex (w_cur_val),
    .o_seg (w_dec)
  );

  assign w_onehot = DIGITS'(1) << r_scan_idx;

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_BLANK;
      r_cnt      <= '0;
      r_scan_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_scan_idx <= w_idx_next;
    end
  end

  // Next-state, counter, slot advance and next output values
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_scan_idx;
    w_digit_next = DIG_OFF;
    w_seg_next   = SEG_OFF;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_next = ST_DRIVE;
          w_cnt_next   = '0;
        end
      end
      ST_DRIVE: begin
        w_seg_next[SEG_DP]      = w_cur_dp ^ ACT_LOW;
        w_seg_next[SEG_G:SEG_A] = w_dec ^ {7{ACT_LOW}};
        if (!w_cur_blank) begin
          w_digit_next = w_onehot ^ DIG_OFF;
        end
        if (r_cnt == DRIVE_LAST) begin
          w_state_next = ST_BLANK;
          w_cnt_next   = '0;
          w_idx_next   = (r_scan_idx == IDX_LAST) ? 3'd0 : r_scan_idx + 3'd1;
        end
      end
      default: begin
        w_state_next = ST_BLANK;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Registered digit/segment drive; reset forces everything inactive at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= DIG_OFF;
      r_seg   <= SEG_OFF;
    end else begin
      r_digit <= w_digit_next;
      r_seg   <= w_seg_next;
    end
  end

  assign digit    = r_digit;
  assign seg      = r_seg;
  assign scan_idx = r_scan_idx;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: directed scenarios followed by random
// writes, checked every cycle against a slot/phase arithmetic model.
module tb_seg_scan;

  localparam int DIGITS    = 6;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int SLOT      = SCAN_DIV + BLANK_CYC;
  localparam int PERIOD    = DIGITS * SLOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_dp = 1'b0;
  logic       wr_blank = 1'b0;
  logic [DIGITS-1:0] digit;
  logic [7:0] seg;
  logic [2:0] scan_idx;

  int n_assert = 0;
  int n_fail = 0;
  int e = 0;

  logic [3:0] m_val [DIGITS];
  logic       m_dp [DIGITS];
  logic       m_blank [DIGITS];

  always #5 clk = ~clk;

  seg_scan #(
    .DIGITS      (DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .SEG_ACT_LOW (0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_dp    (wr_dp),
    .wr_blank (wr_blank),
    .digit    (digit),
    .seg      (seg),
    .scan_idx (scan_idx)
  );

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, e, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DIGITS; i++) begin
      m_val[i]   = 4'd0;
      m_dp[i]    = 1'b0;
      m_blank[i] = 1'b0;
    end
    e = 0;
  endtask

  // One clock: output after this edge shows the slot/phase reached e cycles
  // after reset release, using contents as they stood before this edge.
  task automatic tick();
    int p;
    int slot;
    int ph;
    logic [7:0] exp_seg;
    logic [7:0] exp_dig;
    @(posedge clk);
    p = e % PERIOD;
    slot = p / SLOT;
    ph = p % SLOT;
    exp_seg = 8'h00;
    exp_dig = 8'h00;
    if (ph >= BLANK_CYC) begin
      exp_seg = {m_dp[slot], glyph(m_val[slot])};
      if (!m_blank[slot]) exp_dig = 8'(1) << slot;
    end
    if (wr_en && int'(wr_addr) < DIGITS) begin
      m_val[int'(wr_addr)]   = wr_data;
      m_dp[int'(wr_addr)]    = wr_dp;
      m_blank[int'(wr_addr)] = wr_blank;
    end
    e++;
    @(negedge clk);
    check("digit", {2'b00, digit}, exp_dig);
    check("seg", seg, exp_seg);
    check("scan_idx", {5'b0, scan_idx}, 8'((e % PERIOD) / SLOT));
  endtask

  task automatic do_write(input int a, input int d, input bit dp, input bit bl);
    wr_addr  = 3'(a);
    wr_data  = 4'(d);
    wr_dp    = dp;
    wr_blank = bl;
    wr_en    = 1'b1;
    tick();
    wr_en    = 1'b0;
  endtask

  task automatic advance_to(input int pos);
    for (int i = 0; i < PERIOD && (e % PERIOD) != pos; i++) tick();
  endtask

  initial begin
    model_clear();
    // Reset state
    repeat (3) begin
      @(negedge clk);
      check("rst_digit", {2'b00, digit}, 8'h00);
      check("rst_seg", seg, 8'h00);
      check("rst_scan_idx", {5'b0, scan_idx}, 8'h00);
    end
    rst_n = 1'b1;

    // Free-running scan of the reset contents
    repeat (2 * PERIOD) tick();

    // Out-of-range writes are ignored
    do_write(6, 4'h9, 1'b1, 1'b1);
    do_write(7, 4'hE, 1'b1, 1'b0);
    repeat (PERIOD) tick();

    // Hex A with decimal point on digit 2
    advance_to(0);
    do_write(2, 4'hA, 1'b1, 1'b0);
    repeat (PERIOD) tick();

    // Blank digit 3
    do_write(3, 4'h7, 1'b0, 1'b1);
    repeat (PERIOD) tick();

    // Write digit 1 while it is being driven (second drive cycle)
    advance_to(7);
    do_write(1, 4'h5, 1'b0, 1'b0);
    repeat (PERIOD) tick();

    // Asynchronous reset in the middle of slot 4
    advance_to(22);
    #2 rst_n = 1'b0;
    #1;
    check("async_digit", {2'b00, digit}, 8'h00);
    check("async_seg", seg, 8'h00);
    check("async_scan_idx", {5'b0, scan_idx}, 8'h00);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (PERIOD + SLOT) tick();

    // Random writes, including out-of-range addresses and writes at slot edges
    repeat (300) begin
      if ($urandom_range(0, 3) == 0)
        do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      else
        tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
